w0rm_sync_fifo: RTL
===================

# w0rm_sync_fifo

Elastic buffer for the W0RM sync peripheral path: a single-clock, first-word-fall-through FIFO with valid/ready handshakes on both sides. It sits directly downstream of the synchroniser stage. It absorbs back-pressure from consumers that cannot hold `output_ready` high every cycle, so the synchroniser never drops or stalls data.

## Interface
- `DATA_WIDTH`, default 8: payload width in bits.
- `DEPTH`, default 4: number of entries. Must be a power of two, ≥2.
- `clk` input, 1: single clock, rising edge.
- `reset` input, 1: synchronous, active-high.
- `input_valid` input, 1: upstream word present.
- `input_ready` output, 1: FIFO can accept a word this cycle.
- `input_data` input, DATA_WIDTH: upstream payload.
- `output_valid` output, 1: head word present.
- `output_ready` input, 1: downstream accepts head word.
- `output_data` output, DATA_WIDTH: head word payload.
- `level` output, $clog2(DEPTH)+1: occupancy. Present only with `W0RM_SYNC_FIFO_LEVEL_EN`.

## Operation
- Push: `input_valid && input_ready` at a rising edge. The word is written at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
- Pop: `output_valid && output_ready` at a rising edge. `rd_ptr` increments modulo DEPTH.
- `count` register, width $clog2(DEPTH)+1:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or neither.
- `input_ready` = `!reset && count != DEPTH`. It is combinational from registered state only and never depends on `output_ready`, so there is no pass-through when full.
- `output_valid` = `count != 0`.
- `output_data` = `mem[rd_ptr]` when `count != 0`, else all zeros.
- Full, with `input_valid` and `output_ready` both high: pop only. Count goes to DEPTH−1, and `input_ready` rises the next cycle.
- Empty, with `input_valid` high and `output_ready` high: push only, because no pop is possible while `output_valid` is 0.
- Mid occupancy with push and pop in the same cycle: count is unchanged and both pointers advance.
- Pointer wrap: DEPTH−1 → 0. There is no special casing, because DEPTH is a power of two.
- Reset:
  - Pointers and count go to 0.
  - Memory contents are not cleared; they are unobservable because `output_data` is masked.
  - Any in-flight words are discarded.
  - Handshakes occurring in the reset cycle have no effect.

## Timing
- Reset values:
  - `input_ready` = 0 while `reset` = 1.
  - `input_ready` = 1 from the first cycle after reset deasserts.
  - `output_valid` = 0, `output_data` = 0, `level` = 0.
- Latency: a word pushed at edge N is presented with `output_valid` = 1 after edge N (cycle N+1). That is 1 cycle.
- Throughput: 1 word/cycle sustained whenever 0 < count < DEPTH, or when empty with a push pending.
- Handshake rules:
  - Once asserted, `output_valid` and `output_data` hold stable until popped, except on reset.
  - `input_data` is sampled only on push.
- Order: strict FIFO, with no loss and no duplication.

## Configuration
- `W0RM_SYNC_FIFO_LEVEL_EN`:
  - Defined: the `level` port exists and equals `count`, updated every edge.
  - Undefined: the port is absent. Handshake behaviour is identical in both cases.

## Structure
- Package `w0rm_sync_pkg` holds:
  - the count-width function, `clog2(DEPTH)+1`;
  - the reset constant for pointers/count;
  - the power-of-two check on DEPTH.
- Sub-module `w0rm_sync_fifo_mem`: DEPTH×DATA_WIDTH register array with one synchronous write port and one asynchronous read port. There is no reset on the storage.
- Top level holds the pointers, count, handshake logic and output masking.

## Test plan
- Post-reset idle: hold `reset` for 4 cycles, then release → during reset `input_ready` = 0; after release `input_ready` = 1, `output_valid` = 0, `output_data` = 0x00.
- Streaming: push 0x01..0x10 back-to-back with `output_ready` = 1 → outputs appear in order, each one cycle after its push, 16 pops, `level` never exceeds 1.
- Fill and stall: `output_ready` = 0, push 0xA0..0xA3 (DEPTH 4) → `input_ready` = 0 after the 4th push, a 5th word 0xA4 held valid is not accepted, `level` = 4, head = 0xA0.
- Full with simultaneous request: from full, assert `output_ready` for 1 cycle with 0xA4 still offered → 0xA0 popped, 0xA4 not accepted that cycle, accepted the next cycle; final drain order is A1, A2, A3, A4.
- Wrap-around: run 3×DEPTH words with `output_ready` toggling 1010… → all 12 words out in order, no loss or duplication, pointers wrap cleanly.
- Reset mid-operation: 3 words buffered, pulse `reset` for 1 cycle → next cycle `output_valid` = 0, `level` = 0; subsequent push 0x55 emerges as the first output.

Source files
------------

// File: rtl/w0rm_sync_pkg.sv
// w0rm_sync_pkg
//   Shared definitions for the W0RM sync-path elastic buffer:
//   - cnt_width(): occupancy counter width, clog2(DEPTH)+1, so that the
//     value DEPTH itself (full) is representable.
//   - FIFO_RST_VAL: reset value for the pointers and the occupancy counter.
//   - is_pow2_depth(): elaboration-time legality check on DEPTH.
package w0rm_sync_pkg;

    localparam int unsigned FIFO_RST_VAL = 0;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Pointers wrap for free only when DEPTH is a power of two, >= 2.
    function automatic bit is_pow2_depth(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/w0rm_sync_fifo_mem.sv
// w0rm_sync_fifo_mem
//   DEPTH x DATA_WIDTH register array storage for w0rm_sync_fifo.
//   One synchronous write port, one asynchronous read port, no reset
//   (stale contents are masked by the FIFO output logic).
// Ports:
//   clk       - rising-edge clock
//   i_we      - write enable
//   i_waddr   - write address
//   i_wdata   - write data
//   i_raddr   - read address
//   o_rdata   - read data (combinational from i_raddr)
module w0rm_sync_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/w0rm_sync_fifo.sv
// w0rm_sync_fifo
//   Single-clock first-word-fall-through FIFO with valid/ready handshakes on
//   both sides; elastic buffer downstream of the W0RM synchroniser stage.
//   Optional feature macro: W0RM_SYNC_FIFO_LEVEL_EN (adds the `level` port).
// Ports:
//   clk          - rising-edge clock
//   reset        - synchronous, active-high
//   input_valid  - upstream word present
//   input_ready  - FIFO can accept a word (never depends on output_ready)
//   input_data   - upstream payload, sampled only on push
//   output_valid - head word present
//   output_ready - downstream accepts head word
//   output_data  - head word payload, zero when empty
//   level        - occupancy (only with W0RM_SYNC_FIFO_LEVEL_EN)
module w0rm_sync_fifo
    import w0rm_sync_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          input_valid,
    output logic                          input_ready,
    input  logic [DATA_WIDTH-1:0]         input_data,
    output logic                          output_valid,
    input  logic                          output_ready,
    output logic [DATA_WIDTH-1:0]         output_data
`ifdef W0RM_SYNC_FIFO_LEVEL_EN
    ,
    output logic [cnt_width(DEPTH)-1:0]   level
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    if (!is_pow2_depth(DEPTH)) begin : g_depth_check
        $error("w0rm_sync_fifo: DEPTH must be a power of two and >= 2");
    end

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_not_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_not_empty  = (r_count != CNT_W'(0));
    // Ready comes from registered state only: no pass-through when full.
    assign input_ready  = !reset && (r_count != CNT_W'(DEPTH));
    assign output_valid = w_not_empty;
    assign output_data  = w_not_empty ? w_rd_data : '0;

    assign w_push = input_valid && input_ready;
    assign w_pop  = output_valid && output_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= PTR_W'(FIFO_RST_VAL);
            r_rd_ptr <= PTR_W'(FIFO_RST_VAL);
            r_count  <= CNT_W'(FIFO_RST_VAL);
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    w0rm_sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (input_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

`ifdef W0RM_SYNC_FIFO_LEVEL_EN
    assign level = r_count;
`endif

endmodule
